// File: rtl/axis_frame_averager.sv
// rtl/axis_frame_averager.sv - AXI-Stream multi-lane frame averager using BRAM read-modify-write
//
// Sums CHANNELS signed sample lanes per frame into an external simple-dual-port
// BRAM. A rising edge of AVG_trigger while ARMED starts a frame. Each accepted
// beat is read back from the BRAM, added to the stored sum and written back two
// cycles later. After AVG_frames_count frames the block parks in DONE.
//
// Ports:
//   SYS_aclk, SYS_aresetn         clock, asynchronous active-low reset
//   S_AXIS_tdata/tvalid/tready    sample stream (tready is 1 once out of reset)
//   AVG_trigger                   frame start, rising-edge sensitive
//   AVG_user_reset                synchronous restart to IDLE
//   AVG_samples_count/frames_count configuration, latched in IDLE
//   AVG_result_count              completed frames
//   AVG_busy, AVG_done            status
//   BRAM_PORTA_addr/rddata        read port, 1-cycle read latency
//   BRAM_PORTB_addr/wrdata/we     write port
//   AVG_overflow                  sticky clip flag (only with AVG_SATURATE_EN)
//
// Build option: define AVG_SATURATE_EN to saturate lane sums instead of wrapping.

module axis_frame_averager #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CHANNELS         = 2,
  parameter int ACC_WIDTH        = 32,
  parameter int BRAM_ADDR_WIDTH  = 16
) (
  input  logic                            SYS_aclk,
  input  logic                            SYS_aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                            S_AXIS_tvalid,
  output logic                            S_AXIS_tready,
  input  logic                            AVG_trigger,
  input  logic                            AVG_user_reset,
  input  logic [15:0]                     AVG_samples_count,
  input  logic [15:0]                     AVG_frames_count,
  output logic [15:0]                     AVG_result_count,
  output logic                            AVG_busy,
  output logic                            AVG_done,
  output logic [BRAM_ADDR_WIDTH-1:0]      BRAM_PORTA_addr,
  input  logic [CHANNELS*ACC_WIDTH-1:0]   BRAM_PORTA_rddata,
  output logic [BRAM_ADDR_WIDTH-1:0]      BRAM_PORTB_addr,
  output logic [CHANNELS*ACC_WIDTH-1:0]   BRAM_PORTB_wrdata,
  output logic                            BRAM_PORTB_we
`ifdef AVG_SATURATE_EN
  ,
  output logic                            AVG_overflow
`endif
);

  localparam int LANE_W = AXIS_TDATA_WIDTH / CHANNELS;
  localparam int BRAM_W = CHANNELS * ACC_WIDTH;
  // Wide enough for the 16-bit count and for 2^BRAM_ADDR_WIDTH itself.
  localparam int SQ_W   = (BRAM_ADDR_WIDTH + 1 > 17) ? BRAM_ADDR_WIDTH + 1 : 17;
  localparam logic [SQ_W-1:0] SQ_ONE = SQ_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ACCUMULATE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic                        tready_q;
  logic                        trig_q;
  logic                        drain_q;
  logic [SQ_W-1:0]             samples_q, samples_d, samples_ext, samples_lim;
  logic [SQ_W-1:0]             idx_q;
  logic [15:0]                 frames_q;
  logic [15:0]                 result_count_q, result_inc;
  logic [BRAM_ADDR_WIDTH-1:0]  addr_a_q, addr2_q, addr_b_q;
  logic [AXIS_TDATA_WIDTH-1:0] samp1_q, samp2_q;
  logic                        v1_q, v2_q, we_q;
  logic [BRAM_W-1:0]           wrdata_q, wrdata_d;
  logic                        accept, trig_edge, last_sample, first_frame;

`ifdef AVG_SATURATE_EN
  localparam int SUM_W = ACC_WIDTH + 1;
  logic signed [SUM_W-1:0] lane_sum, lane_rd;
  logic                    ovf_d, ovf_q;
  assign AVG_overflow = ovf_q;
`endif

  // Frame length is clipped to the BRAM depth.
  assign samples_ext = {{(SQ_W-16){1'b0}}, AVG_samples_count};
  assign samples_lim = SQ_ONE << BRAM_ADDR_WIDTH;
  assign samples_d   = (samples_ext > samples_lim) ? samples_lim : samples_ext;

  assign accept      = (state_q == S_ACCUMULATE) && S_AXIS_tvalid && tready_q;
  assign trig_edge   = AVG_trigger && !trig_q;
  assign last_sample = (idx_q == samples_q - SQ_ONE);
  assign result_inc  = result_count_q + 16'd1;
  // result_count only moves at the end of DRAIN, so it is stable for a whole frame.
  assign first_frame = (result_count_q == 16'd0);

  assign S_AXIS_tready     = tready_q;
  assign AVG_result_count  = result_count_q;
  assign BRAM_PORTA_addr   = addr_a_q;
  assign BRAM_PORTB_addr   = addr_b_q;
  assign BRAM_PORTB_wrdata = wrdata_q;
  assign BRAM_PORTB_we     = we_q;

  // State register
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (AVG_user_reset) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (AVG_samples_count != 16'd0 && AVG_frames_count != 16'd0) begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_edge) begin
            state_d = S_ACCUMULATE;
          end
        end
        S_ACCUMULATE: begin
          if (accept && last_sample) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            state_d = (result_inc == frames_q) ? S_DONE : S_ARMED;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs
  always_comb begin
    AVG_busy = 1'b0;
    AVG_done = 1'b0;
    case (state_q)
      S_ACCUMULATE, S_DRAIN: AVG_busy = 1'b1;
      S_DONE:                AVG_done = 1'b1;
      default: ;
    endcase
  end

  // Per-lane sum of the delayed sample and the word read back from the BRAM.
  // The first frame after a restart ignores whatever the BRAM holds.
  always_comb begin
    wrdata_d = '0;
`ifdef AVG_SATURATE_EN
    ovf_d    = 1'b0;
    lane_sum = '0;
    lane_rd  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lane_rd  = first_frame ? '0 : SUM_W'($signed(BRAM_PORTA_rddata[k*ACC_WIDTH +: ACC_WIDTH]));
      lane_sum = SUM_W'($signed(samp2_q[k*LANE_W +: LANE_W])) + lane_rd;
      // One guard bit: disagreement with the sign bit means out of range.
      if (lane_sum[SUM_W-1] != lane_sum[SUM_W-2]) begin
        ovf_d = 1'b1;
        wrdata_d[k*ACC_WIDTH +: ACC_WIDTH] = lane_sum[SUM_W-1] ?
          {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        wrdata_d[k*ACC_WIDTH +: ACC_WIDTH] = lane_sum[ACC_WIDTH-1:0];
      end
    end
`else
    for (int k = 0; k < CHANNELS; k++) begin
      wrdata_d[k*ACC_WIDTH +: ACC_WIDTH] =
        ACC_WIDTH'($signed(samp2_q[k*LANE_W +: LANE_W])) +
        (first_frame ? '0 : BRAM_PORTA_rddata[k*ACC_WIDTH +: ACC_WIDTH]);
    end
`endif
  end

  // Datapath: accept (addr/lanes) -> wait for read data -> write back.
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      tready_q       <= 1'b0;
      trig_q         <= 1'b0;
      drain_q        <= 1'b0;
      samples_q      <= '0;
      frames_q       <= '0;
      idx_q          <= '0;
      result_count_q <= '0;
      addr_a_q       <= '0;
      addr2_q        <= '0;
      addr_b_q       <= '0;
      samp1_q        <= '0;
      samp2_q        <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      we_q           <= 1'b0;
      wrdata_q       <= '0;
`ifdef AVG_SATURATE_EN
      ovf_q          <= 1'b0;
`endif
    end else begin
      tready_q <= 1'b1;
      trig_q   <= AVG_trigger;
      if (AVG_user_reset) begin
        // Squash everything in flight; BRAM contents are left as they are.
        drain_q        <= 1'b0;
        idx_q          <= '0;
        result_count_q <= '0;
        v1_q           <= 1'b0;
        v2_q           <= 1'b0;
        we_q           <= 1'b0;
`ifdef AVG_SATURATE_EN
        ovf_q          <= 1'b0;
`endif
      end else begin
        if (state_q == S_IDLE) begin
          samples_q      <= samples_d;
          frames_q       <= AVG_frames_count;
          result_count_q <= '0;
        end
        if (state_q == S_ARMED) begin
          idx_q   <= '0;
          drain_q <= 1'b0;
        end
        if (accept) begin
          idx_q    <= idx_q + SQ_ONE;
          addr_a_q <= idx_q[BRAM_ADDR_WIDTH-1:0];
          samp1_q  <= S_AXIS_tdata;
        end
        v1_q    <= accept;
        v2_q    <= v1_q;
        samp2_q <= samp1_q;
        addr2_q <= addr_a_q;
        we_q    <= v2_q;
        if (v2_q) begin
          addr_b_q <= addr2_q;
          wrdata_q <= wrdata_d;
`ifdef AVG_SATURATE_EN
          ovf_q    <= ovf_q | ovf_d;
`endif
        end
        if (state_q == S_DRAIN) begin
          drain_q <= ~drain_q;
          if (drain_q) begin
            result_count_q <= result_inc;
          end
        end
      end
    end
  end

endmodule
